serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have parameter DIGIT, default 1, bits added per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request an addition; sampled on the rising clk edge.
REQ-006 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port ci  input  1  carry-in to bit 0.
REQ-009 SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result has completed.
REQ-011 SHALL have port sum  output  WIDTH  result of the last completed addition.
REQ-012 SHALL have port co  output  1  carry-out of bit WIDTH-1 of the last result.
REQ-013 SHALL have port ovf  output  1  signed overflow of the last result.

Function
REQ-014 SHALL implement a three-state FSM:
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1.
REQ-015 In IDLE or DONE with start=1 at an edge, the block SHALL latch a, b and ci, clear the digit counter and enter RUN.
REQ-016 In RUN, each edge SHALL add the next DIGIT-bit slice, least-significant slice first, using the carry produced by the previous slice.
REQ-017 The carry into slice 0 SHALL be the latched ci.
REQ-018 After exactly WIDTH/DIGIT RUN edges, the FSM SHALL enter DONE; on that same edge sum, co and ovf SHALL update.
REQ-019 From DONE without start, the FSM SHALL return to IDLE on the next edge.
REQ-020 Latency SHALL be WIDTH/DIGIT+1 edges, counted from the start-accepting edge to the edge at which done rises; done SHALL be high for exactly one cycle unless restarted.
REQ-021 start in DONE SHALL be accepted (back-to-back operation); done SHALL still pulse for one cycle only, and busy SHALL rise on the next edge.
REQ-022 start while in RUN SHALL be ignored; the operands latched for the in-flight operation SHALL remain unchanged.
REQ-023 Changes on a, b or ci after the accepting edge SHALL NOT affect the result in progress.
REQ-024 sum, co and ovf SHALL hold their values from the DONE transition until the next DONE transition; intermediate partial sums SHALL NOT be visible on these ports.
REQ-025 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-026 sum SHALL equal (a+b+ci) mod 2^WIDTH, and co SHALL equal bit WIDTH of the full sum.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force:
- FSM to IDLE;
- busy=0, done=0, sum=0, co=0, ovf=0;
- counter and operand registers to 0.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-029 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With macro SERIAL_ADDER_SUB_EN defined:
- the block SHALL add input port sub, 1 bit, latched with the operands;
- sub=1 SHALL compute a + ~b + 1, with ci ignored;
- co SHALL then be the no-borrow flag (1 when a>=b unsigned);
- ovf SHALL keep the definition of REQ-025.
REQ-031 Without SERIAL_ADDER_SUB_EN, port sub SHALL NOT exist and the block SHALL add only.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-032 a=0x5A, b=0x33, ci=0, start one cycle -> busy for 8 cycles; done at edge 9; sum=0x8D, co=0, ovf=1.
REQ-033 a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1, ovf=0; then a=0x7F, b=0x00, ci=1 issued in the DONE cycle -> accepted back-to-back; sum=0x80, co=0, ovf=1.
REQ-034 start pulsed again at RUN cycle 3 with a=0x01, b=0x01 -> ignored; result is that of the first operands; exactly one done pulse.
REQ-035 rst_n low at RUN cycle 4 -> busy, done, sum, co and ovf are 0 immediately; no done pulse afterwards; a new start after release completes normally.
REQ-036 DIGIT=4, a=0x9C, b=0x64, ci=0 -> done at edge 3; sum=0x00, co=1, ovf=0.
REQ-037 SERIAL_ADDER_SUB_EN defined, sub=1, a=0x10, b=0x20 -> sum=0xF0, co=0, ovf=0; a=0x80, b=0x01 -> sum=0x7F, co=1, ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles, LSB slice first.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDX_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, acc_q, acc_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx;
    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   sl_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             last;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Subtraction is folded in at latch time: store ~b and force the carry-in to 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : ci;
`else
    assign b_in = b;
    assign c_in = ci;
`endif

    assign last = (cnt_q == LAST);

    always_comb begin
        idx     = IDX_W'(cnt_q) * IDX_W'(DIGIT);
        a_sl    = op_a_q[idx +: DIGIT];
        b_sl    = op_b_q[idx +: DIGIT];
        sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + (DIGIT + 1)'(carry_q);
        // Carry into the slice MSB, recovered from its sum bit; on the last slice this is bit WIDTH-1.
        msb_cin = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ sl_sum[DIGIT-1];
        acc_d   = acc_q;
        acc_d[idx +: DIGIT] = sl_sum[DIGIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else if (state_q != S_RUN) begin
            if (start) begin
                op_a_q  <= a;
                op_b_q  <= b_in;
                carry_q <= c_in;
                cnt_q   <= '0;
            end
        end else begin
            carry_q <= sl_sum[DIGIT];
            acc_q   <= acc_d;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                sum <= acc_d;
                co  <= sl_sum[DIGIT];
                ovf <= msb_cin ^ sl_sum[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8, DIGIT=1 and DIGIT=4 instances).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, ci = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, co, ovf;
    logic [7:0] sum;

    logic       start4 = 1'b0, ci4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, co4, ovf4;
    logic [7:0] sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0, sub4 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .ci(ci), .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .a(a4), .b(b4), .ci(ci4), .busy(busy4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation on the DIGIT=1 instance and checks latency, busy span and result.
    // b2b: start is presented in the current (DONE or post-reset) cycle without waiting a negedge.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vci, input logic vsub, input logic b2b, input int glitch_at,
                          input logic [7:0] e_sum, input logic e_co, input logic e_ovf);
        int lat, busy_cycles;
        bit seen;
        if (!b2b) @(negedge clk);
        a = va; b = vb; ci = vci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = vsub;
`else
        if (vsub) $display("note: %s requests sub without SERIAL_ADDER_SUB_EN", tag);
`endif
        @(posedge clk); #1;
        start = 1'b0; a = ~va; b = 8'hA5; ci = ~vci;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ~vsub;
`endif
        if (b2b) check({tag, "_done_low"}, 64'(done), 64'd0);
        lat = 1; busy_cycles = 0; seen = 1'b0;
        while (lat < 40 && !seen) begin
            if (busy) busy_cycles++;
            if (lat == glitch_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            seen = done;
        end
        check({tag, "_latency"}, 64'(lat), 64'd9);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd8);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'(e_sum));
        check({tag, "_co"}, 64'(co), 64'(e_co));
        check({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int pulses = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    task automatic run_op4(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic vci, input logic [7:0] e_sum, input logic e_co,
                           input logic e_ovf);
        int lat;
        @(negedge clk);
        a4 = va; b4 = vb; ci4 = vci; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 8'h00; b4 = 8'hFF;
        lat = 1;
        while (lat < 20 && !done4) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_sum"}, 64'(sum4), 64'(e_sum));
        check({tag, "_co"}, 64'(co4), 64'(e_co));
        check({tag, "_ovf"}, 64'(ovf4), 64'(e_ovf));
    endtask

    initial begin
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_co", 64'(co), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        // Start presented at release: must be taken on the very first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b1, -1, 8'h8D, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, -1, 8'h00, 1'b1, 1'b0);
        run_op("b2b_7f_00", 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, -1, 8'h80, 1'b0, 1'b1);
        check("b2b_sum_held_idle", 64'(sum), 64'h80);

        run_op("ignore_start", 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 3, 8'h8D, 1'b0, 1'b1);
        watch_no_done("ignore_start_single_done", 12);

        // Abort mid-run: outputs clear asynchronously and no done follows.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_co", 64'(co), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("abort_no_done", 12);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, -1, 8'h00, 1'b1, 1'b1);
        run_op("add_aa_55_c", 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, -1, 8'h00, 1'b1, 1'b0);

        run_op4("d4_9c_64", 8'h9C, 8'h64, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op4("d4_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, -1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, -1, 8'h7F, 1'b1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
